uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive front end for the VC709 board top.
- Sits directly downstream of the `RxD` pad: it consumes the serial line in the `clk_o` domain produced by the clock wizard.
- Delivers bytes to the command/debug logic through a valid/ready holding register.
- Frame format is 8N1, LSB first, with 16x oversampling and mid-bit sampling.

Parameters:
- CLK_FREQ, 100_000_000, frequency of `clk` in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit. Must be an even number >= 8.
- Derived DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), using integer truncation. Must be >= 2. The default gives 54.

Ports:
- clk  in  1  system clock (`clk_o` from the clock wizard)
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  raw serial input, asynchronous to `clk`
- rx_data  out  8  received byte, stable while `rx_valid`=1
- rx_valid  out  1  byte available
- rx_ready  in  1  consumer accepts; transfer occurs when `rx_valid` && `rx_ready`
- rx_busy  out  1  high while state != IDLE
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- overrun  out  1  one-cycle pulse when a byte is dropped because the holding register is full

Behaviour:
- Reset (async assert, sync release via `rst_n`):
  - 2-FF synchronizer on `rxd` resets to 1.
  - State = IDLE. Divider and tick counters = 0. Shift register = 0.
  - `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - Reset asserted mid-frame abandons the frame immediately; no partial byte is delivered.
- Synchronized input `rxs` is the 2nd flop output. All decisions use `rxs`.
- Tick generator:
  - Counter runs 0..DIV-1.
  - `tick` = 1 when counter == DIV-1; the counter then wraps to 0.
  - Counter is held at 0 in IDLE, so it is re-phased at each start edge.
- IDLE:
  - On `rxs`=0, go to START and clear the tick count.
- START:
  - At tick count OVERSAMPLE/2-1 (mid start bit), sample `rxs`.
  - If `rxs`=0: go to DATA and clear the tick count and bit index.
  - If `rxs`=1: false start. Return to IDLE with no output activity.
- DATA:
  - Every OVERSAMPLE ticks (mid-bit), shift `rxs` in at MSB: `sh <= {rxs, sh[7:1]}`.
  - After bit index 7, go to STOP.
- STOP:
  - After OVERSAMPLE ticks, sample `rxs`.
  - If `rxs`=1: commit the byte (see below), then go to IDLE.
  - If `rxs`=0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rxs`=1, then go to IDLE.
  - This covers break conditions and prevents a spurious restart.
- Commit, evaluated in the cycle after the stop-bit sample:
  - `rx_valid`=0: load `rx_data`; `rx_valid`<=1.
  - `rx_valid`=1 and `rx_ready`=1 in that same cycle: load the new byte and keep `rx_valid`=1. No overrun.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, pulse `overrun` for 1 cycle, drop the new byte.
- Handshake:
  - `rx_valid` falls the cycle after `rx_valid`&&`rx_ready`, unless a commit occurs in that same cycle.
  - `rx_data` changes only on commit.
- Latency: `rx_valid` rises 1 cycle after the stop-bit mid-sample. That is about 9.5 bit times + 3 cycles after the start edge on `rxd`.
- `frame_err` and `overrun` are mutually exclusive and never asserted together.
- A new start edge is accepted on the first IDLE cycle after the stop sample. Back-to-back frames with no idle gap must be received.

Test Plan:
- Use CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 (DIV=10, 160 clk/bit).
- Send 0xA5 8N1 with `rx_ready`=1 → `rx_valid` for exactly 1 cycle with `rx_data`=0xA5. No `frame_err`/`overrun`. `rx_busy` high from start edge+2 until the stop sample.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle gap and `rx_ready`=1 → three transfers in order: 0x00, 0xFF, 0x3C.
- Pull `rxd` low for 60 clk, then high → no `rx_valid`, state returns to IDLE, `rx_busy` low. A following 0x5A is received correctly.
- Send 0x81 with the stop bit driven 0, then hold low 2000 clk → `frame_err` 1-cycle pulse, no `rx_valid`, `rx_busy` stays high until `rxd` returns high. A following 0x42 is received.
- `rx_ready`=0; send 0x11 then 0x22 → `rx_data`=0x11 held, `overrun` pulses at the second commit. Raise `rx_ready` → one transfer of 0x11, then `rx_valid`=0. Repeat with `rx_ready` pulsed in the commit cycle of 0x22 → 0x22 is loaded and there is no `overrun`.
- Assert `rst_n`=0 during data bit 4 of 0x99, release, then send 0x77 → all outputs 0 during reset, no delivery of 0x99, 0x77 received.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, oversampled mid-bit sampling,
// and a single-entry valid/ready holding register with overrun/frame error pulses.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TCK_W-1:0] MID_START = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] BIT_LAST  = TCK_W'(OVERSAMPLE - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TCK_W-1:0] tck_q, tck_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             commit_q, commit_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             tick, samp;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      div_q     <= '0;
      tck_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      commit_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      commit_q  <= commit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  // Divider is parked at 0 in IDLE so every frame is phased to its start edge.
  assign tick = (state_q != IDLE) && (div_q == DIV_LAST);
  assign samp = tick && (((state_q == START) && (tck_q == MID_START)) ||
                         (((state_q == DATA) || (state_q == STOP)) && (tck_q == BIT_LAST)));

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxs_q) state_d = START;
      START:     if (samp) state_d = rxs_q ? IDLE : DATA;
      DATA:      if (samp && bit_q == 3'd7) state_d = STOP;
      STOP:      if (samp) state_d = rxs_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------- datapath / holding register ----------------
  always_comb begin
    div_d    = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    tck_d    = tck_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    if (state_q == IDLE || samp) tck_d = '0;
    else if (tick)               tck_d = tck_q + 1'b1;
    if (state_q == START) bit_d = '0;
    if (state_q == DATA && samp) begin
      sh_d  = {rxs_q, sh_q[7:1]};
      bit_d = bit_q + 1'b1;
    end
    commit_d = (state_q == STOP) && samp && rxs_q;
    fe_d     = (state_q == STOP) && samp && !rxs_q;

    // A commit wins over a same-cycle handshake; a full register drops the new byte.
    data_d  = data_q;
    valid_d = valid_q && !rx_ready;
    ov_d    = 1'b0;
    if (commit_q) begin
      if (!valid_q || rx_ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    rx_busy   = (state_q != IDLE);
    rx_data   = data_q;
    rx_valid  = valid_q;
    frame_err = fe_q;
    overrun   = ov_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are sent
// and compared against handshakes captured by a negedge monitor.
module tb_uart_rx;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int vec = 0;
  int err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int rd = 0;
  int fe_cnt = 0, ov_cnt = 0, vcyc = 0, both_cnt = 0;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
      if (rx_valid) vcyc++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    step(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    step(3);
    vec++; if (rx_data !== 8'h00) begin err++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    vec++; if (rx_busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    vec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      err++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun);
    end
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_single;
    int v0, f0, o0;
    logic [7:0] d;
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    rxd = 1'b0;
    step(8);
    vec++; if (rx_busy !== 1'b1) begin err++; $display("FAIL single_busy_start: got %b expected 1", rx_busy); end
    step(BIT - 8);
    for (int i = 0; i < 8; i++) send_bit(d_a5(i));
    send_bit(1'b1);
    step(5);
    vec++; if (rx_busy !== 1'b0) begin err++; $display("FAIL single_busy_end: got %b expected 0", rx_busy); end
    vec++; if (vcyc - v0 != 1) begin err++; $display("FAIL single_valid_len: got %0d expected 1", vcyc - v0); end
    vec++; if (fe_cnt != f0 || ov_cnt != o0) begin
      err++; $display("FAIL single_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL single_data: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL single_data: got %h expected %h", obs_q[rd], d); end rd++; end
    end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL single_extra: got %0d expected %0d", obs_q.size(), rd); end
  endtask

  function automatic logic d_a5(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

  task automatic test_back_to_back;
    logic [7:0] pat[3];
    logic [7:0] d;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C;
    rx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(pat[k]);
      send_frame(pat[k], 1'b1);
    end
    step(10);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL b2b_data: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL b2b_data: got %h expected %h", obs_q[rd], d); end rd++; end
    end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL b2b_extra: got %0d expected %0d", obs_q.size(), rd); end
  endtask

  task automatic test_false_start;
    logic [7:0] d;
    rx_ready = 1'b1;
    rxd = 1'b0;
    step(60);
    rxd = 1'b1;
    step(100);
    vec++; if (rx_busy !== 1'b0) begin err++; $display("FAIL false_busy: got %b expected 0", rx_busy); end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL false_no_byte: got %0d expected %0d", obs_q.size(), rd); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    step(5);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL false_data: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL false_data: got %h expected %h", obs_q[rd], d); end rd++; end
    end
  endtask

  task automatic test_frame_err;
    int f0;
    logic [7:0] d;
    f0 = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b0);
    step(2000);
    vec++; if (fe_cnt - f0 != 1) begin err++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - f0); end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL ferr_no_byte: got %0d expected %0d", obs_q.size(), rd); end
    vec++; if (rx_busy !== 1'b1) begin err++; $display("FAIL ferr_busy_hold: got %b expected 1", rx_busy); end
    rxd = 1'b1;
    step(10);
    vec++; if (rx_busy !== 1'b0) begin err++; $display("FAIL ferr_busy_release: got %b expected 0", rx_busy); end
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    step(5);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL ferr_data: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL ferr_data: got %h expected %h", obs_q[rd], d); end rd++; end
    end
  endtask

  task automatic test_overrun;
    int o0;
    logic [7:0] d;
    o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(5);
    vec++; if (ov_cnt - o0 != 1) begin err++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - o0); end
    vec++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      err++; $display("FAIL ovr_hold: got %h/%b expected 11/1", rx_data, rx_valid);
    end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL ovr_no_xfer: got %0d expected %0d", obs_q.size(), rd); end
    exp_q.push_back(8'h11);
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    step(3);
    vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL ovr_drain_valid: got %b expected 0", rx_valid); end

    // Second pass: the handshake lands exactly in the commit cycle of 0x22.
    o0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        step(1523);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end
    join
    step(5);
    vec++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin
      err++; $display("FAIL ovr_commit_load: got %h/%b expected 22/1", rx_data, rx_valid);
    end
    vec++; if (ov_cnt != o0) begin err++; $display("FAIL ovr_commit_none: got %0d expected 0", ov_cnt - o0); end
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    step(3);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL ovr_data: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL ovr_data: got %h expected %h", obs_q[rd], d); end rd++; end
    end
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL ovr_extra: got %0d expected %0d", obs_q.size(), rd); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] v;
    logic [7:0] d;
    v = 8'h99;
    rx_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    rxd = v[4];
    step(BIT / 2);
    rst_n = 1'b0;
    step(2);
    vec++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      err++; $display("FAIL rst_mid_data: got %h/%b expected 00/0", rx_data, rx_valid);
    end
    vec++; if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      err++; $display("FAIL rst_mid_flags: got busy=%b fe=%b ov=%b expected 0 0 0", rx_busy, frame_err, overrun);
    end
    rxd = 1'b1;
    step(10);
    rst_n = 1'b1;
    step(BIT * 12);
    vec++; if (obs_q.size() != rd) begin err++; $display("FAIL rst_mid_no_byte: got %0d expected %0d", obs_q.size(), rd); end
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    step(5);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      vec++;
      if (rd >= obs_q.size()) begin err++; $display("FAIL rst_mid_data77: got none expected %h", d); end
      else begin if (obs_q[rd] !== d) begin err++; $display("FAIL rst_mid_data77: got %h expected %h", obs_q[rd], d); end rd++; end
    end
    vec++; if (both_cnt != 0) begin err++; $display("FAIL fe_ov_exclusive: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
